// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-lookup, flush and retire signals of the reorder buffer.
// slave is the buffer itself; master is the surrounding pipeline.
interface reorder_buffer_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              alloc_valid;
  logic [4:0]        alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_robNum;

  logic              CDBiscast;
  logic [TAG_W-1:0]  CDBrobNum;
  logic [DATA_W-1:0] CDBdata;
  logic              CDBiscast2;
  logic [TAG_W-1:0]  CDBrobNum2;
  logic [DATA_W-1:0] CDBdata2;

  logic [TAG_W-1:0]  index;
  logic              ready;
  logic [DATA_W-1:0] value;

  logic              flush;

  logic              commit_valid;
  logic [4:0]        commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_robNum;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  alloc_valid, alloc_dest,
    output alloc_ready, alloc_robNum,
    input  CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2,
    input  index,
    output ready, value,
    input  flush,
    output commit_valid, commit_dest, commit_data, commit_robNum, count
  );

  modport master (
    output alloc_valid, alloc_dest,
    input  alloc_ready, alloc_robNum,
    output CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2,
    output index,
    input  ready, value,
    output flush,
    input  commit_valid, commit_dest, commit_data, commit_robNum, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: hands out tags, captures two CDB channels, answers
// zero-latency operand lookups and retires one entry per cycle in program order.
module reorder_buffer #(
  parameter int DEPTH       = 16,
  parameter int TAG_W       = 6,
  parameter int INVALID_TAG = 16,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  reorder_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] INV_TAG = TAG_W'(INVALID_TAG);

  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  done_reg;
  logic [4:0]        dest_reg [DEPTH];
  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              commit_valid_reg;
  logic [4:0]        commit_dest_reg;
  logic [DATA_W-1:0] commit_data_reg;
  logic [TAG_W-1:0]  commit_robnum_reg;

  logic              full;
  logic              alloc_fire;
  logic              commit_fire;
  logic [DEPTH-1:0]  alloc_sel;
  logic [DEPTH-1:0]  retire_sel;
  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  hit2;
  logic [DEPTH-1:0]  cap_en;

  // Fullness looks at the count at the start of the cycle, so a retire in the
  // same cycle never opens a slot early.
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign alloc_fire  = bus.alloc_valid && !full && !bus.flush;
  assign commit_fire = busy_reg[head_reg] && done_reg[head_reg] && !bus.flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign hit1[gi]       = bus.CDBiscast  && (bus.CDBrobNum  == TAG_W'(gi));
      assign hit2[gi]       = bus.CDBiscast2 && (bus.CDBrobNum2 == TAG_W'(gi));
      assign cap_en[gi]     = busy_reg[gi] && !done_reg[gi] && (hit1[gi] || hit2[gi]) && !bus.flush;
      assign alloc_sel[gi]  = alloc_fire  && (tail_reg == PTR_W'(gi));
      assign retire_sel[gi] = commit_fire && (head_reg == PTR_W'(gi));
    end
  endgenerate

  // Alloc only targets a free slot and retire only the busy head, so the two
  // selects never overlap and a freshly allocated slot cannot capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
      done_reg <= '0;
    end else if (bus.flush) begin
      busy_reg <= '0;
      done_reg <= '0;
    end else begin
      busy_reg <= (busy_reg | alloc_sel) & ~retire_sel;
      done_reg <= (done_reg | cap_en) & ~alloc_sel & ~retire_sel;
    end
  end

  // Payload storage carries no reset; busy/done qualify every read of it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_sel[i]) dest_reg[i] <= bus.alloc_dest;
      if (cap_en[i])    data_reg[i] <= hit1[i] ? bus.CDBdata : bus.CDBdata2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (bus.flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_fire)  tail_reg <= tail_reg + 1'b1;
      if (commit_fire) head_reg <= head_reg + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_valid_reg  <= 1'b0;
      commit_dest_reg   <= '0;
      commit_data_reg   <= '0;
      commit_robnum_reg <= INV_TAG;
    end else if (commit_fire) begin
      commit_valid_reg  <= 1'b1;
      commit_dest_reg   <= dest_reg[head_reg];
      commit_data_reg   <= data_reg[head_reg];
      commit_robnum_reg <= TAG_W'(head_reg);
    end else begin
      commit_valid_reg  <= 1'b0;
      commit_robnum_reg <= INV_TAG;
    end
  end

  logic [PTR_W-1:0]  lk_idx;
  logic              lk_ready;
  logic [DATA_W-1:0] lk_value;

  assign lk_idx = bus.index[PTR_W-1:0];

  // Stored result first, then same-cycle CDB bypass, channel 1 ahead of 2.
  always_comb begin
    lk_ready = 1'b0;
    lk_value = '0;
    if ((bus.index < TAG_W'(DEPTH)) && busy_reg[lk_idx]) begin
      if (done_reg[lk_idx]) begin
        lk_ready = 1'b1;
        lk_value = data_reg[lk_idx];
      end else if (bus.CDBiscast && (bus.CDBrobNum == bus.index)) begin
        lk_ready = 1'b1;
        lk_value = bus.CDBdata;
      end else if (bus.CDBiscast2 && (bus.CDBrobNum2 == bus.index)) begin
        lk_ready = 1'b1;
        lk_value = bus.CDBdata2;
      end
    end
  end

  assign bus.ready         = lk_ready;
  assign bus.value         = lk_value;
  assign bus.alloc_ready   = !full;
  assign bus.alloc_robNum  = full ? INV_TAG : TAG_W'(tail_reg);
  assign bus.commit_valid  = commit_valid_reg;
  assign bus.commit_dest   = commit_dest_reg;
  assign bus.commit_data   = commit_data_reg;
  assign bus.commit_robNum = commit_robnum_reg;
  assign bus.count         = count_reg;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, CDB capture, lookup bypass,
// in-order retire, full/wrap, flush and asynchronous reset.
module tb_reorder_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  reorder_buffer_if rob_if ();

  reorder_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (rob_if)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    rob_if.alloc_valid = 1'b0;
    rob_if.alloc_dest  = 5'd0;
    rob_if.CDBiscast   = 1'b0;
    rob_if.CDBrobNum   = 6'd0;
    rob_if.CDBdata     = 32'd0;
    rob_if.CDBiscast2  = 1'b0;
    rob_if.CDBrobNum2  = 6'd0;
    rob_if.CDBdata2    = 32'd0;
    rob_if.index       = 6'd0;
    rob_if.flush       = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b0;
    tick();
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data}
        !== {1'b1 ^ 1'b1, 6'd16, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_commit got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data},
               {1'b0, 6'd16, 5'd0, 32'd0});
    end
    checks++;
    if ({rob_if.alloc_ready, rob_if.alloc_robNum, rob_if.count} !== {1'b1, 6'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_alloc got=%h exp=%h",
               {rob_if.alloc_ready, rob_if.alloc_robNum, rob_if.count}, {1'b1, 6'd0, 5'd0});
    end
    reset = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_alloc;
    for (int i = 0; i < 3; i++) begin
      rob_if.alloc_valid = 1'b1;
      rob_if.alloc_dest  = 5'(5 + i);
      #1;
      checks++;
      if ({rob_if.alloc_ready, rob_if.alloc_robNum} !== {1'b1, 6'(i)}) begin
        failures++;
        $display("FAIL alloc_tag%0d got=%h exp=%h", i, {rob_if.alloc_ready, rob_if.alloc_robNum}, {1'b1, 6'(i)});
      end
      tick();
      $display("alloc tag=%0d dest=%0d", i, 5 + i);
      checks++;
      if (rob_if.commit_valid !== 1'b0) begin
        failures++;
        $display("FAIL alloc_no_commit%0d got=%b exp=0", i, rob_if.commit_valid);
      end
    end
    rob_if.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rob_if.count !== 5'd3) begin
      failures++;
      $display("FAIL alloc_count got=%0d exp=3", rob_if.count);
    end
  endtask

  task automatic test_back_to_back;
    rob_if.CDBiscast = 1'b1;
    rob_if.CDBrobNum = 6'd1;
    rob_if.CDBdata   = 32'h55;
    tick();
    rob_if.CDBrobNum = 6'd0;
    rob_if.CDBdata   = 32'hAA;
    tick();
    rob_if.CDBiscast = 1'b0;
    #1;
    checks++;
    if (rob_if.commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early got=%b exp=0", rob_if.commit_valid);
    end
    tick();
    $display("commit tag=%0d dest=%0d data=%h", rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data);
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data}
        !== {1'b1, 6'd0, 5'd5, 32'hAA}) begin
      failures++;
      $display("FAIL b2b_commit0 got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data},
               {1'b1, 6'd0, 5'd5, 32'hAA});
    end
    tick();
    $display("commit tag=%0d dest=%0d data=%h", rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data);
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data, rob_if.count}
        !== {1'b1, 6'd1, 5'd6, 32'h55, 5'd1}) begin
      failures++;
      $display("FAIL b2b_commit1 got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data, rob_if.count},
               {1'b1, 6'd1, 5'd6, 32'h55, 5'd1});
    end
  endtask

  task automatic test_lookup;
    rob_if.index      = 6'd2;
    rob_if.CDBiscast2 = 1'b1;
    rob_if.CDBrobNum2 = 6'd2;
    rob_if.CDBdata2   = 32'h1234;
    #1;
    checks++;
    if ({rob_if.ready, rob_if.value} !== {1'b1, 32'h1234}) begin
      failures++;
      $display("FAIL lookup_bypass got=%h exp=%h", {rob_if.ready, rob_if.value}, {1'b1, 32'h1234});
    end
    tick();
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum} !== {1'b0, 6'd16}) begin
      failures++;
      $display("FAIL lookup_idle got=%h exp=%h", {rob_if.commit_valid, rob_if.commit_robNum}, {1'b0, 6'd16});
    end
    rob_if.CDBiscast2 = 1'b0;
    #1;
    checks++;
    if ({rob_if.ready, rob_if.value} !== {1'b1, 32'h1234}) begin
      failures++;
      $display("FAIL lookup_stored got=%h exp=%h", {rob_if.ready, rob_if.value}, {1'b1, 32'h1234});
    end
    rob_if.index = 6'd16;
    #1;
    checks++;
    if ({rob_if.ready, rob_if.value} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL lookup_invalid got=%h exp=%h", {rob_if.ready, rob_if.value}, {1'b0, 32'h0});
    end
    rob_if.index = 6'd0;
    #1;
    checks++;
    if ({rob_if.ready, rob_if.value} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL lookup_notbusy got=%h exp=%h", {rob_if.ready, rob_if.value}, {1'b0, 32'h0});
    end
    tick();
    $display("commit tag=%0d dest=%0d data=%h", rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data);
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data, rob_if.count}
        !== {1'b1, 6'd2, 5'd7, 32'h1234, 5'd0}) begin
      failures++;
      $display("FAIL lookup_commit2 got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data, rob_if.count},
               {1'b1, 6'd2, 5'd7, 32'h1234, 5'd0});
    end
  endtask

  task automatic test_dual_cdb;
    for (int i = 0; i < 2; i++) begin
      rob_if.alloc_valid = 1'b1;
      rob_if.alloc_dest  = 5'(8 + i);
      #1;
      checks++;
      if (rob_if.alloc_robNum !== 6'(3 + i)) begin
        failures++;
        $display("FAIL dual_alloc%0d got=%0d exp=%0d", i, rob_if.alloc_robNum, 3 + i);
      end
      tick();
    end
    rob_if.alloc_valid = 1'b0;
    rob_if.CDBiscast   = 1'b1;
    rob_if.CDBrobNum   = 6'd3;
    rob_if.CDBdata     = 32'h11;
    rob_if.CDBiscast2  = 1'b1;
    rob_if.CDBrobNum2  = 6'd3;
    rob_if.CDBdata2    = 32'h22;
    tick();
    rob_if.CDBrobNum  = 6'd4;
    rob_if.CDBdata    = 32'h44;
    rob_if.CDBdata2   = 32'h99;
    rob_if.index      = 6'd3;
    #1;
    checks++;
    if ({rob_if.ready, rob_if.value} !== {1'b1, 32'h11}) begin
      failures++;
      $display("FAIL dual_same_tag got=%h exp=%h", {rob_if.ready, rob_if.value}, {1'b1, 32'h11});
    end
    tick();
    $display("commit tag=%0d dest=%0d data=%h", rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data);
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data}
        !== {1'b1, 6'd3, 5'd8, 32'h11}) begin
      failures++;
      $display("FAIL dual_commit3 got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data},
               {1'b1, 6'd3, 5'd8, 32'h11});
    end
    clear_inputs();
    rob_if.index = 6'd4;
    #1;
    checks++;
    if ({rob_if.ready, rob_if.value} !== {1'b1, 32'h44}) begin
      failures++;
      $display("FAIL dual_lookup4 got=%h exp=%h", {rob_if.ready, rob_if.value}, {1'b1, 32'h44});
    end
    tick();
    $display("commit tag=%0d dest=%0d data=%h", rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data);
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data}
        !== {1'b1, 6'd4, 5'd9, 32'h44}) begin
      failures++;
      $display("FAIL dual_commit4 got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data},
               {1'b1, 6'd4, 5'd9, 32'h44});
    end
  endtask

  task automatic test_flush;
    rob_if.alloc_valid = 1'b1;
    rob_if.alloc_dest  = 5'd10;
    tick();
    rob_if.alloc_dest  = 5'd11;
    tick();
    rob_if.alloc_valid = 1'b0;
    rob_if.CDBiscast   = 1'b1;
    rob_if.CDBrobNum   = 6'd6;
    rob_if.CDBdata     = 32'h66;
    rob_if.CDBiscast2  = 1'b1;
    rob_if.CDBrobNum2  = 6'd5;
    rob_if.CDBdata2    = 32'h55;
    tick();
    clear_inputs();
    rob_if.flush       = 1'b1;
    rob_if.alloc_valid = 1'b1;
    rob_if.alloc_dest  = 5'd12;
    tick();
    $display("flush");
    clear_inputs();
    rob_if.index = 6'd5;
    #1;
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.count, rob_if.alloc_robNum, rob_if.ready}
        !== {1'b0, 6'd16, 5'd0, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL flush_state got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.count, rob_if.alloc_robNum, rob_if.ready},
               {1'b0, 6'd16, 5'd0, 6'd0, 1'b0});
    end
    tick();
    checks++;
    if ({rob_if.commit_valid, rob_if.count} !== {1'b0, 5'd0}) begin
      failures++;
      $display("FAIL flush_after got=%h exp=%h", {rob_if.commit_valid, rob_if.count}, {1'b0, 5'd0});
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 16; i++) begin
      rob_if.alloc_valid = 1'b1;
      rob_if.alloc_dest  = 5'(i + 1);
      #1;
      checks++;
      if ({rob_if.alloc_ready, rob_if.alloc_robNum} !== {1'b1, 6'(i)}) begin
        failures++;
        $display("FAIL full_alloc%0d got=%h exp=%h", i, {rob_if.alloc_ready, rob_if.alloc_robNum}, {1'b1, 6'(i)});
      end
      tick();
    end
    rob_if.alloc_dest = 5'd30;
    #1;
    checks++;
    if ({rob_if.alloc_ready, rob_if.alloc_robNum, rob_if.count} !== {1'b0, 6'd16, 5'd16}) begin
      failures++;
      $display("FAIL full_flag got=%h exp=%h",
               {rob_if.alloc_ready, rob_if.alloc_robNum, rob_if.count}, {1'b0, 6'd16, 5'd16});
    end
    tick();
    rob_if.alloc_dest = 5'd31;
    rob_if.CDBiscast  = 1'b1;
    rob_if.CDBrobNum  = 6'd0;
    rob_if.CDBdata    = 32'hC0DE;
    tick();
    rob_if.CDBiscast = 1'b0;
    tick();
    $display("commit tag=%0d dest=%0d data=%h", rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data);
    checks++;
    if ({rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data, rob_if.count}
        !== {1'b1, 6'd0, 5'd1, 32'hC0DE, 5'd15}) begin
      failures++;
      $display("FAIL full_commit got=%h exp=%h",
               {rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data, rob_if.count},
               {1'b1, 6'd0, 5'd1, 32'hC0DE, 5'd15});
    end
    checks++;
    if ({rob_if.alloc_ready, rob_if.alloc_robNum} !== {1'b1, 6'd0}) begin
      failures++;
      $display("FAIL full_wrap_tag got=%h exp=%h", {rob_if.alloc_ready, rob_if.alloc_robNum}, {1'b1, 6'd0});
    end
    tick();
    rob_if.alloc_valid = 1'b0;
    rob_if.index       = 6'd0;
    #1;
    checks++;
    if ({rob_if.count, rob_if.alloc_robNum, rob_if.commit_valid, rob_if.ready}
        !== {5'd16, 6'd16, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL full_refill got=%h exp=%h",
               {rob_if.count, rob_if.alloc_robNum, rob_if.commit_valid, rob_if.ready},
               {5'd16, 6'd16, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    rob_if.flush = 1'b1;
    tick();
    rob_if.flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rob_if.alloc_valid = 1'b1;
      rob_if.alloc_dest  = 5'(i + 1);
      tick();
    end
    rob_if.alloc_valid = 1'b0;
    rob_if.CDBiscast   = 1'b1;
    rob_if.CDBrobNum   = 6'd1;
    rob_if.CDBdata     = 32'hD1;
    rob_if.CDBiscast2  = 1'b1;
    rob_if.CDBrobNum2  = 6'd2;
    rob_if.CDBdata2    = 32'hD2;
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({rob_if.count, rob_if.commit_valid} !== {5'd5, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_pre got=%h exp=%h", {rob_if.count, rob_if.commit_valid}, {5'd5, 1'b0});
    end
    #1;
    reset = 1'b0;
    #1;
    $display("async reset asserted");
    checks++;
    if ({rob_if.count, rob_if.alloc_robNum, rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data}
        !== {5'd0, 6'd0, 1'b0, 6'd16, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL rstmid_state got=%h exp=%h",
               {rob_if.count, rob_if.alloc_robNum, rob_if.commit_valid, rob_if.commit_robNum, rob_if.commit_dest, rob_if.commit_data},
               {5'd0, 6'd0, 1'b0, 6'd16, 5'd0, 32'd0});
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rob_if.commit_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_no_commit%0d got=%b exp=0", i, rob_if.commit_valid);
      end
    end
    rob_if.alloc_valid = 1'b1;
    rob_if.alloc_dest  = 5'd9;
    #1;
    checks++;
    if (rob_if.alloc_robNum !== 6'd0) begin
      failures++;
      $display("FAIL rstmid_next_tag got=%0d exp=0", rob_if.alloc_robNum);
    end
    tick();
    rob_if.alloc_valid = 1'b0;
    #1;
    checks++;
    if (rob_if.count !== 5'd1) begin
      failures++;
      $display("FAIL rstmid_count got=%0d exp=1", rob_if.count);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_back_to_back();
    test_lookup();
    test_dual_cdb();
    test_flush();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
